// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment bus frame decoder:
// segment patterns (bit6=a .. bit0=g, active low) and digit select codes.
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [3:0] SEL_D0   = 4'b0111;
    localparam logic [3:0] SEL_D1   = 4'b1011;
    localparam logic [3:0] SEL_D2   = 4'b1101;
    localparam logic [3:0] SEL_D3   = 4'b1110;
    localparam logic [3:0] SEL_NONE = 4'b1111;

    localparam logic [3:0] DIGIT_BAD = 4'hF;

    typedef enum logic [2:0] {
        ST_BLANK,
        ST_SYNC,
        ST_COLLECT1,
        ST_COLLECT2,
        ST_COLLECT3
    } state_e;

    typedef struct packed {
        logic       one_hot;
        logic [1:0] index;
    } sel_info_t;

    // Maps an active-low select to its digit position; one_hot=0 for none or multi-zero.
    function automatic sel_info_t sel_decode(input logic [3:0] sel);
        sel_info_t info;
        info = '{one_hot: 1'b0, index: 2'd0};
        case (sel)
            SEL_D0:  info = '{one_hot: 1'b1, index: 2'd0};
            SEL_D1:  info = '{one_hot: 1'b1, index: 2'd1};
            SEL_D2:  info = '{one_hot: 1'b1, index: 2'd2};
            SEL_D3:  info = '{one_hot: 1'b1, index: 2'd3};
            default: info = '{one_hot: 1'b0, index: 2'd0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/seg_frame_decoder_if.sv
// Display bus seen by the decoder: sampled segment/select pins in, reconstructed frame out.
interface seg_frame_decoder_if;
    logic [6:0] seg_c;
    logic [3:0] seg_a;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [6:0] tt_value;
    logic [6:0] tm_value;
    logic       frame_valid;
    logic       blank;
    logic       sync_lost;
    logic       seg_err;
    logic       sel_err;

    modport master (
        output seg_c, seg_a,
        input  digit0, digit1, digit2, digit3, tt_value, tm_value,
        input  frame_valid, blank, sync_lost, seg_err, sel_err
    );

    modport slave (
        input  seg_c, seg_a,
        output digit0, digit1, digit2, digit3, tt_value, tm_value,
        output frame_valid, blank, sync_lost, seg_err, sel_err
    );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to BCD digit; unknown patterns give DIGIT_BAD.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       valid_o,
    output logic [3:0] digit_o
);

    always_comb begin
        valid_o = 1'b1;
        digit_o = DIGIT_BAD;
        case (pattern_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: begin
                valid_o = 1'b0;
                digit_o = DIGIT_BAD;
            end
        endcase
    end

endmodule

// File: rtl/seg_frame_decoder.sv
// Receive-side monitor for the multiplexed 7-segment bus: debounces each digit dwell,
// tracks scan order and commits complete 4-digit frames with their two 2-digit values.
module seg_frame_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int BLANK_CYCLES  = 100000
) (
    input  logic                clk,
    input  logic                rst,
    seg_frame_decoder_if.slave  bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int BLK_W = $clog2(BLANK_CYCLES + 1);

    logic [6:0]       seg_q;
    logic [3:0]       sel_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] bcnt_q, bcnt_d;

    logic             dec_valid;
    logic [3:0]       dec_digit;
    sel_info_t        sel_info;
    logic             stable_hit;
    logic             accept;
    logic             sel_bad;
    logic             timeout;

    state_e           state_q;
    logic [3:0]       part_q  [3];
    logic [3:0]       digit_q [4];
    logic [6:0]       tt_q;
    logic [6:0]       tm_q;
    logic             frame_valid_q;
    logic             blank_q;
    logic             sync_lost_q;
    logic             seg_err_q;
    logic             sel_err_q;

    function automatic logic [6:0] pair_value(input logic [3:0] tens, input logic [3:0] units);
        if (tens == DIGIT_BAD || units == DIGIT_BAD) begin
            return 7'h7F;
        end
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

    // Stage 0: pin sample register and dwell counters
    always_comb begin
        cnt_d = cnt_q;
        if ({bus.seg_c, bus.seg_a} != {seg_q, sel_q}) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        bcnt_d = '0;
        if (sel_q == SEL_NONE) begin
            bcnt_d = (bcnt_q == BLK_W'(BLANK_CYCLES)) ? bcnt_q : bcnt_q + BLK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q  <= 7'h7F;
            sel_q  <= SEL_NONE;
            cnt_q  <= '0;
            bcnt_q <= '0;
        end else begin
            seg_q  <= bus.seg_c;
            sel_q  <= bus.seg_a;
            cnt_q  <= cnt_d;
            bcnt_q <= bcnt_d;
        end
    end

    seg_pattern_decode u_decode (
        .pattern_i (seg_q),
        .valid_o   (dec_valid),
        .digit_o   (dec_digit)
    );

    // The counter saturates past STABLE_CYCLES-1, so each dwell hits exactly once.
    assign sel_info   = sel_decode(sel_q);
    assign stable_hit = (cnt_q == CNT_W'(STABLE_CYCLES - 1));
    assign accept     = stable_hit && sel_info.one_hot;
    assign sel_bad    = stable_hit && !sel_info.one_hot && (sel_q != SEL_NONE);
    assign timeout    = (sel_q == SEL_NONE) && (bcnt_q == BLK_W'(BLANK_CYCLES - 1));

    // Stage 1: scan-order FSM and committed frame registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BLANK;
            part_q        <= '{default: 4'd0};
            digit_q       <= '{default: 4'd0};
            tt_q          <= '0;
            tm_q          <= '0;
            frame_valid_q <= 1'b0;
            blank_q       <= 1'b1;
            sync_lost_q   <= 1'b0;
            seg_err_q     <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            sync_lost_q   <= 1'b0;
            if (timeout) begin
                state_q <= ST_BLANK;
                blank_q <= 1'b1;
            end else if (sel_bad) begin
                sel_err_q <= 1'b1;
                state_q   <= ST_SYNC;
                blank_q   <= 1'b0;
            end else if (accept) begin
                blank_q <= 1'b0;
                if (!dec_valid) begin
                    seg_err_q <= 1'b1;
                end
                if (sel_info.index == 2'd0) begin
                    // A digit0 always (re)starts a frame; mid-frame it means the scan slipped.
                    part_q[0] <= dec_digit;
                    state_q   <= ST_COLLECT1;
                    if (state_q != ST_BLANK && state_q != ST_SYNC) begin
                        sync_lost_q <= 1'b1;
                    end
                end else begin
                    case (state_q)
                        ST_COLLECT1: begin
                            if (sel_info.index == 2'd1) begin
                                part_q[1] <= dec_digit;
                                state_q   <= ST_COLLECT2;
                            end else begin
                                sync_lost_q <= 1'b1;
                                state_q     <= ST_SYNC;
                            end
                        end
                        ST_COLLECT2: begin
                            if (sel_info.index == 2'd2) begin
                                part_q[2] <= dec_digit;
                                state_q   <= ST_COLLECT3;
                            end else begin
                                sync_lost_q <= 1'b1;
                                state_q     <= ST_SYNC;
                            end
                        end
                        ST_COLLECT3: begin
                            if (sel_info.index == 2'd3) begin
                                digit_q[0]    <= part_q[0];
                                digit_q[1]    <= part_q[1];
                                digit_q[2]    <= part_q[2];
                                digit_q[3]    <= dec_digit;
                                tt_q          <= pair_value(part_q[0], part_q[1]);
                                tm_q          <= pair_value(part_q[2], dec_digit);
                                frame_valid_q <= 1'b1;
                            end else begin
                                sync_lost_q <= 1'b1;
                            end
                            state_q <= ST_SYNC;
                        end
                        default: state_q <= ST_SYNC;
                    endcase
                end
            end
        end
    end

    assign bus.digit0      = digit_q[0];
    assign bus.digit1      = digit_q[1];
    assign bus.digit2      = digit_q[2];
    assign bus.digit3      = digit_q[3];
    assign bus.tt_value    = tt_q;
    assign bus.tm_value    = tm_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.blank       = blank_q;
    assign bus.sync_lost   = sync_lost_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.sel_err     = sel_err_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Scoreboard bench for seg_frame_decoder: scans are driven on the pins, expected
// frames queued, and every frame_valid pulse is popped and compared.
module tb_seg_frame_decoder;

    localparam int SC = 16;
    localparam int BC = 300;
    localparam int DWELL = 40;

    typedef struct packed {
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic [6:0] tt;
        logic [6:0] tm;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_frame_decoder_if bus();

    seg_frame_decoder #(
        .STABLE_CYCLES (SC),
        .BLANK_CYCLES  (BC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] PAT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    logic [3:0] SELS [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    frame_t sb[$];
    frame_t last_exp;
    int     checks = 0;
    int     errors = 0;
    int     frames_seen = 0;
    int     frames_exp = 0;
    int     sl_pulses = 0;

    function automatic logic [6:0] pat_of(input int v);
        if (v > 9) return 7'h7F;
        return PAT[v];
    endfunction

    function automatic logic [6:0] exp_pair(input int a, input int b);
        if (a > 9 || b > 9) return 7'h7F;
        return 7'(a * 10 + b);
    endfunction

    task automatic expect_frame(input int a, input int b, input int c, input int e);
        frame_t f;
        f.d0 = 4'(a);
        f.d1 = 4'(b);
        f.d2 = 4'(c);
        f.d3 = 4'(e);
        f.tt = exp_pair(a, b);
        f.tm = exp_pair(c, e);
        sb.push_back(f);
        last_exp = f;
        frames_exp++;
    endtask

    task automatic drive_pins(input logic [3:0] sel, input logic [6:0] seg, input int n);
        @(negedge clk);
        bus.seg_a = sel;
        bus.seg_c = seg;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic scan(input int a, input int b, input int c, input int e);
        drive_pins(SELS[0], pat_of(a), DWELL);
        drive_pins(SELS[1], pat_of(b), DWELL);
        drive_pins(SELS[2], pat_of(c), DWELL);
        drive_pins(SELS[3], pat_of(e), DWELL);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sync_lost) sl_pulses++;
            if (bus.frame_valid) begin
                frame_t e;
                frames_seen++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected actual %h%h%h%h tt=%0d tm=%0d required no frame",
                             bus.digit0, bus.digit1, bus.digit2, bus.digit3, bus.tt_value, bus.tm_value);
                end else begin
                    e = sb.pop_front();
                    if ({bus.digit0, bus.digit1, bus.digit2, bus.digit3, bus.tt_value, bus.tm_value}
                        !== {e.d0, e.d1, e.d2, e.d3, e.tt, e.tm}) begin
                        errors++;
                        $display("FAIL frame_content actual %h%h%h%h tt=%h tm=%h required %h%h%h%h tt=%h tm=%h",
                                 bus.digit0, bus.digit1, bus.digit2, bus.digit3, bus.tt_value, bus.tm_value,
                                 e.d0, e.d1, e.d2, e.d3, e.tt, e.tm);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        bus.seg_a = 4'b1111;
        bus.seg_c = 7'h7F;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.digit0, bus.digit1, bus.digit2, bus.digit3} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_digits actual %h%h%h%h required 0000", bus.digit0, bus.digit1, bus.digit2, bus.digit3);
        end
        checks++;
        if ({bus.tt_value, bus.tm_value} !== 14'd0) begin
            errors++;
            $display("FAIL reset_values actual tt=%0d tm=%0d required 0 0", bus.tt_value, bus.tm_value);
        end
        checks++;
        if ({bus.frame_valid, bus.blank, bus.sync_lost, bus.seg_err, bus.sel_err} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_flags actual fv,bl,sl,se,sle=%b required 01000",
                     {bus.frame_valid, bus.blank, bus.sync_lost, bus.seg_err, bus.sel_err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame;
        expect_frame(3, 3, 1, 2);
        drive_pins(SELS[0], pat_of(3), DWELL);
        drive_pins(SELS[1], pat_of(3), DWELL);
        drive_pins(SELS[2], pat_of(1), DWELL);
        @(negedge clk);
        bus.seg_a = SELS[3];
        bus.seg_c = pat_of(2);
        @(posedge clk);
        repeat (SC - 1) @(posedge clk);
        #1;
        checks++;
        if (bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL commit_early actual fv=%b required 0 at edge E+%0d", bus.frame_valid, SC - 1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.tt_value !== 7'd33 || bus.tm_value !== 7'd12) begin
            errors++;
            $display("FAIL commit_timing actual fv=%b tt=%0d tm=%0d required 1 33 12",
                     bus.frame_valid, bus.tt_value, bus.tm_value);
        end
        repeat (DWELL - SC) @(negedge clk);
        checks++;
        if (bus.blank !== 1'b0 || frames_seen != 1) begin
            errors++;
            $display("FAIL single_frame actual blank=%b frames=%0d required 0 1", bus.blank, frames_seen);
        end
    endtask

    task automatic test_back_to_back;
        int f0, s0;
        f0 = frames_seen;
        s0 = sl_pulses;
        for (int r = 0; r < 3; r++) begin
            expect_frame(3, 3, 1, 2);
            scan(3, 3, 1, 2);
        end
        checks++;
        if (frames_seen != f0 + 3 || sl_pulses != s0) begin
            errors++;
            $display("FAIL back_to_back actual frames=%0d sync_lost=%0d required %0d %0d",
                     frames_seen - f0, sl_pulses - s0, 3, 0);
        end
    endtask

    task automatic test_order;
        int s0;
        s0 = sl_pulses;
        drive_pins(SELS[0], pat_of(5), DWELL);
        drive_pins(SELS[1], pat_of(7), DWELL);
        drive_pins(SELS[3], pat_of(9), DWELL);
        checks++;
        if (sl_pulses != s0 + 1) begin
            errors++;
            $display("FAIL skip_digit actual sync_lost=%0d required 1", sl_pulses - s0);
        end
        expect_frame(6, 0, 4, 8);
        drive_pins(SELS[0], pat_of(1), DWELL);
        drive_pins(SELS[1], pat_of(2), DWELL);
        drive_pins(SELS[0], pat_of(6), DWELL);
        drive_pins(SELS[1], pat_of(0), DWELL);
        drive_pins(SELS[2], pat_of(4), DWELL);
        drive_pins(SELS[3], pat_of(8), DWELL);
        checks++;
        if (sl_pulses != s0 + 2) begin
            errors++;
            $display("FAIL restart_digit0 actual sync_lost=%0d required 2", sl_pulses - s0);
        end
        expect_frame(5, 7, 0, 9);
        scan(5, 7, 0, 9);
    endtask

    task automatic test_bad_segment;
        expect_frame(4, 2, 15, 8);
        scan(4, 2, 15, 8);
        checks++;
        if (bus.seg_err !== 1'b1 || bus.digit2 !== 4'hF || bus.tm_value !== 7'h7F) begin
            errors++;
            $display("FAIL bad_segment actual seg_err=%b d2=%h tm=%h required 1 f 7f",
                     bus.seg_err, bus.digit2, bus.tm_value);
        end
        expect_frame(9, 9, 9, 9);
        scan(9, 9, 9, 9);
        checks++;
        if (bus.seg_err !== 1'b1 || bus.tt_value !== 7'd99) begin
            errors++;
            $display("FAIL seg_err_sticky actual seg_err=%b tt=%0d required 1 99", bus.seg_err, bus.tt_value);
        end
    endtask

    task automatic test_blank;
        @(negedge clk);
        bus.seg_a = 4'b1111;
        bus.seg_c = 7'h7F;
        @(posedge clk);
        repeat (BC - 1) @(posedge clk);
        #1;
        checks++;
        if (bus.blank !== 1'b0) begin
            errors++;
            $display("FAIL blank_early actual %b required 0", bus.blank);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.blank !== 1'b1) begin
            errors++;
            $display("FAIL blank_rise actual %b required 1", bus.blank);
        end
        repeat (20) @(negedge clk);
        checks++;
        if ({bus.digit0, bus.digit1, bus.digit2, bus.digit3, bus.tt_value, bus.tm_value}
            !== {last_exp.d0, last_exp.d1, last_exp.d2, last_exp.d3, last_exp.tt, last_exp.tm}
            || bus.blank !== 1'b1) begin
            errors++;
            $display("FAIL blank_hold actual %h%h%h%h tt=%0d blank=%b required %h%h%h%h tt=%0d blank=1",
                     bus.digit0, bus.digit1, bus.digit2, bus.digit3, bus.tt_value, bus.blank,
                     last_exp.d0, last_exp.d1, last_exp.d2, last_exp.d3, last_exp.tt);
        end
    endtask

    task automatic test_sel_err;
        int s0, f0;
        drive_pins(4'b1001, pat_of(5), SC + 4);
        checks++;
        if (bus.sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err actual %b required 1", bus.sel_err);
        end
        s0 = sl_pulses;
        f0 = frames_seen;
        drive_pins(SELS[1], pat_of(1), DWELL);
        drive_pins(SELS[2], pat_of(2), DWELL);
        drive_pins(SELS[3], pat_of(3), DWELL);
        checks++;
        if (sl_pulses != s0 || frames_seen != f0) begin
            errors++;
            $display("FAIL sync_ignore actual sync_lost=%0d frames=%0d required 0 0",
                     sl_pulses - s0, frames_seen - f0);
        end
        expect_frame(2, 5, 5, 0);
        scan(2, 5, 5, 0);
        checks++;
        if (bus.blank !== 1'b0) begin
            errors++;
            $display("FAIL blank_fall actual %b required 0", bus.blank);
        end
    endtask

    task automatic test_reset_midframe;
        drive_pins(SELS[0], pat_of(7), DWELL);
        drive_pins(SELS[1], pat_of(4), SC + 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.digit0, bus.digit1, bus.digit2, bus.digit3, bus.tt_value, bus.tm_value} !== 30'd0) begin
            errors++;
            $display("FAIL reset_mid_values actual %h%h%h%h tt=%0d tm=%0d required 0000 0 0",
                     bus.digit0, bus.digit1, bus.digit2, bus.digit3, bus.tt_value, bus.tm_value);
        end
        checks++;
        if ({bus.blank, bus.seg_err, bus.sel_err} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_flags actual bl,se,sle=%b required 100", {bus.blank, bus.seg_err, bus.sel_err});
        end
        rst = 1'b0;
        drive_pins(SELS[2], pat_of(3), DWELL);
        drive_pins(SELS[3], pat_of(6), DWELL);
        expect_frame(8, 1, 0, 7);
        scan(8, 1, 0, 7);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_order();
        test_bad_segment();
        test_blank();
        test_sel_err();
        test_reset_midframe();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0 || frames_seen != frames_exp) begin
            errors++;
            $display("FAIL frame_count actual %0d pending=%0d required %0d", frames_seen, sb.size(), frames_exp);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
